// File: rtl/fft_ctrl.sv
// Control sequencer for the single-butterfly FFT datapath: debounces one push-button
// and steps through operand loads, multiply, add/sub and result display.
module fft_ctrl #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CAL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       button,
  output logic       load_Rea,
  output logic       load_Ima,
  output logic       load_Reb,
  output logic       load_Imb,
  output logic       load_Rew,
  output logic       load_Imw,
  output logic       mul_en,
  output logic       cal_en,
  output logic       display_Rey,
  output logic       display_Imy,
  output logic       display_Rez,
  output logic       display_Imz,
  output logic       busy,
  output logic [3:0] step
);

  localparam int unsigned DebW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned PhMax = (MUL_CYCLES > CAL_CYCLES) ? MUL_CYCLES : CAL_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);

  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);
  localparam logic [PhW-1:0]  MulLast = PhW'(MUL_CYCLES - 1);
  localparam logic [PhW-1:0]  CalLast = PhW'(CAL_CYCLES - 1);

  typedef enum logic [3:0] {
    StARe = 4'd0,
    StAIm = 4'd1,
    StBRe = 4'd2,
    StBIm = 4'd3,
    StWRe = 4'd4,
    StWIm = 4'd5,
    StMul = 4'd6,
    StCal = 4'd7,
    StYRe = 4'd8,
    StYIm = 4'd9,
    StZRe = 4'd10,
    StZIm = 4'd11
  } state_e;

  logic            sync1_q, sync_q;
  logic [DebW-1:0] deb_cnt_q;
  logic            db_q, db_prev_q;
  logic            press;

  state_e          state_q, state_d;
  logic [PhW-1:0]  phase_q, phase_d;
  logic [5:0]      load_d;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sync1_q   <= 1'b0;
      sync_q    <= 1'b0;
      deb_cnt_q <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      sync1_q   <= button;
      sync_q    <= sync1_q;
      db_prev_q <= db_q;
      if (sync_q == db_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DebLast) begin
        db_q      <= sync_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    load_d  = '0;
    case (state_q)
      StARe: if (press) begin state_d = StAIm; load_d[0] = 1'b1; end
      StAIm: if (press) begin state_d = StBRe; load_d[1] = 1'b1; end
      StBRe: if (press) begin state_d = StBIm; load_d[2] = 1'b1; end
      StBIm: if (press) begin state_d = StWRe; load_d[3] = 1'b1; end
      StWRe: if (press) begin state_d = StWIm; load_d[4] = 1'b1; end
      StWIm: begin
        if (press) begin
          state_d   = StMul;
          load_d[5] = 1'b1;
          phase_d   = '0;
        end
      end
      // Presses in the busy phases are simply dropped.
      StMul: begin
        if (phase_q == MulLast) begin
          state_d = StCal;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StCal: begin
        if (phase_q == CalLast) begin
          state_d = StYRe;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StYRe: if (press) state_d = StYIm;
      StYIm: if (press) state_d = StZRe;
      StZRe: if (press) state_d = StZIm;
      StZIm: if (press) state_d = StARe;
      default: state_d = StARe;
    endcase
  end

  // Level outputs are registered from the next state so they line up with step.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StARe;
      phase_q     <= '0;
      load_Rea    <= 1'b0;
      load_Ima    <= 1'b0;
      load_Reb    <= 1'b0;
      load_Imb    <= 1'b0;
      load_Rew    <= 1'b0;
      load_Imw    <= 1'b0;
      mul_en      <= 1'b0;
      cal_en      <= 1'b0;
      display_Rey <= 1'b0;
      display_Imy <= 1'b0;
      display_Rez <= 1'b0;
      display_Imz <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      load_Rea    <= load_d[0];
      load_Ima    <= load_d[1];
      load_Reb    <= load_d[2];
      load_Imb    <= load_d[3];
      load_Rew    <= load_d[4];
      load_Imw    <= load_d[5];
      mul_en      <= (state_d == StMul);
      cal_en      <= (state_d == StCal);
      display_Rey <= (state_d == StYRe);
      display_Imy <= (state_d == StYIm);
      display_Rez <= (state_d == StZRe);
      display_Imz <= (state_d == StZIm);
      busy        <= (state_d == StMul) || (state_d == StCal);
    end
  end

  assign step = state_q;

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl: reset, debounce, full load/compute/display run,
// busy-phase press rejection (long-phase instance) and mid-run reset.
module tb_fft_ctrl;

  logic       clk = 1'b0;
  logic       Reset;
  logic       button, button2;
  logic [5:0] ld, ld2;
  logic       mul_en, cal_en, busy;
  logic       mul2, cal2, busy2;
  logic [3:0] disp, disp2;
  logic [3:0] step, step2;

  always #5 clk = ~clk;

  fft_ctrl dut (
    .clk(clk), .Reset(Reset), .button(button),
    .load_Rea(ld[0]), .load_Ima(ld[1]), .load_Reb(ld[2]),
    .load_Imb(ld[3]), .load_Rew(ld[4]), .load_Imw(ld[5]),
    .mul_en(mul_en), .cal_en(cal_en),
    .display_Rey(disp[0]), .display_Imy(disp[1]),
    .display_Rez(disp[2]), .display_Imz(disp[3]),
    .busy(busy), .step(step)
  );

  // Long busy phases so a full debounced press fits inside MUL.
  fft_ctrl #(.DEB_CYCLES(16), .MUL_CYCLES(60), .CAL_CYCLES(60)) dut2 (
    .clk(clk), .Reset(Reset), .button(button2),
    .load_Rea(ld2[0]), .load_Ima(ld2[1]), .load_Reb(ld2[2]),
    .load_Imb(ld2[3]), .load_Rew(ld2[4]), .load_Imw(ld2[5]),
    .mul_en(mul2), .cal_en(cal2),
    .display_Rey(disp2[0]), .display_Imy(disp2[1]),
    .display_Rez(disp2[2]), .display_Imz(disp2[3]),
    .busy(busy2), .step(step2)
  );

  int ntotal = 0;
  int nbad   = 0;

  int nld[6];
  int nmul = 0, ncal = 0, nover = 0, nmulti = 0, nbusy = 0;
  int nld2 = 0, nmul2 = 0, ncal2 = 0;
  int cyc = 0, mul_last = 0, cal_first = 0;
  logic cal_prev = 1'b0;

  initial for (int i = 0; i < 6; i++) nld[i] = 0;

  always @(negedge clk) begin
    int nhi;
    cyc++;
    nhi = 0;
    for (int i = 0; i < 6; i++) begin
      if (ld[i]) begin
        nld[i]++;
        nhi++;
      end
    end
    if (nhi > 1) nmulti++;
    if (mul_en) begin
      nmul++;
      mul_last = cyc;
    end
    if (cal_en) ncal++;
    if (cal_en && !cal_prev) cal_first = cyc;
    cal_prev = cal_en;
    if (mul_en && cal_en) nover++;
    if (busy !== (mul_en | cal_en)) nbusy++;
    if (ld2 != 6'd0) nld2++;
    if (mul2) nmul2++;
    if (cal2) ncal2++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_press(input bit second);
    if (second) button2 = 1'b1; else button = 1'b1;
    wait_cyc(40);
    if (second) button2 = 1'b0; else button = 1'b0;
    wait_cyc(40);
  endtask

  // One clean press; idx < 0 means no load pulse is expected.
  task automatic press_check(input int idx, input int exp_step, input logic [3:0] exp_disp);
    int snap[6];
    int sum;
    logic [5:0] mask;
    for (int i = 0; i < 6; i++) snap[i] = nld[i];
    do_press(1'b0);
    sum  = 0;
    mask = '0;
    for (int i = 0; i < 6; i++) begin
      sum += nld[i] - snap[i];
      if (nld[i] - snap[i] == 1) mask[i] = 1'b1;
    end
    check("load_pulses", sum, (idx < 0) ? 0 : 1);
    check("load_which", {26'd0, mask}, (idx < 0) ? 0 : (32'd1 << idx));
    check("step", {28'd0, step}, exp_step);
    check("display", {28'd0, disp}, {28'd0, exp_disp});
  endtask

  initial begin
    int snap_mul, snap_cal, snap_ld2, k;
    Reset   = 1'b1;
    button  = 1'b0;
    button2 = 1'b0;
    wait_cyc(3);
    check("rst_step", {28'd0, step}, 0);
    check("rst_outs", {20'd0, ld, mul_en, cal_en, busy, disp}, 0);
    Reset = 1'b0;
    wait_cyc(5);

    // Hold 200 cycles: one press only.
    button = 1'b1;
    wait_cyc(200);
    button = 1'b0;
    wait_cyc(40);
    check("hold_rea", nld[0], 1);
    check("hold_step", {28'd0, step}, 1);

    // Bounce then stable high: exactly one press.
    for (int i = 0; i < 5; i++) begin
      button = ~i[0];
      wait_cyc(3);
    end
    button = 1'b1;
    wait_cyc(40);
    button = 1'b0;
    wait_cyc(40);
    check("bounce_ima", nld[1], 1);
    check("bounce_step", {28'd0, step}, 2);

    // 10-cycle glitch: no press.
    button = 1'b1;
    wait_cyc(10);
    button = 1'b0;
    wait_cyc(40);
    check("glitch_reb", nld[2], 0);
    check("glitch_step", {28'd0, step}, 2);

    press_check(2, 3, 4'b0000);
    press_check(3, 4, 4'b0000);
    press_check(4, 5, 4'b0000);
    snap_mul = nmul;
    snap_cal = ncal;
    press_check(5, 8, 4'b0001);
    check("mul_len", nmul - snap_mul, 4);
    check("cal_len", ncal - snap_cal, 4);
    check("mul_cal_gap", cal_first, mul_last + 1);
    check("busy_done", {31'd0, busy}, 0);

    press_check(-1, 9, 4'b0010);
    press_check(-1, 10, 4'b0100);
    press_check(-1, 11, 4'b1000);
    press_check(-1, 0, 4'b0000);
    press_check(0, 1, 4'b0000);

    // Back to W_IM, then reset in the middle of MUL.
    press_check(1, 2, 4'b0000);
    press_check(2, 3, 4'b0000);
    press_check(3, 4, 4'b0000);
    press_check(4, 5, 4'b0000);
    button = 1'b1;
    k = 0;
    while (!mul_en && k < 60) begin
      wait_cyc(1);
      k++;
    end
    check("mul_reached", {31'd0, mul_en}, 1);
    wait_cyc(1);
    Reset = 1'b1;
    #1;
    check("rst_mul_en", {31'd0, mul_en}, 0);
    check("rst_mid_step", {28'd0, step}, 0);
    button = 1'b0;
    wait_cyc(3);
    Reset = 1'b0;
    wait_cyc(5);
    press_check(0, 1, 4'b0000);

    // Presses during MUL on the long-phase instance are discarded.
    for (int i = 0; i < 5; i++) do_press(1'b1);
    check("d2_step_wim", {28'd0, step2}, 5);
    snap_ld2 = nld2;
    snap_mul = nmul2;
    snap_cal = ncal2;
    button2 = 1'b1;
    k = 0;
    while (!mul2 && k < 60) begin
      wait_cyc(1);
      k++;
    end
    check("d2_mul_reached", {31'd0, mul2}, 1);
    button2 = 1'b0;
    wait_cyc(25);
    button2 = 1'b1;
    wait_cyc(30);
    button2 = 1'b0;
    wait_cyc(100);
    check("d2_no_strobe", nld2 - snap_ld2, 1);
    check("d2_mul_len", nmul2 - snap_mul, 60);
    check("d2_cal_len", ncal2 - snap_cal, 60);
    check("d2_step", {28'd0, step2}, 8);
    check("d2_display", {28'd0, disp2}, 4'b0001);

    check("multi_load", nmulti, 0);
    check("mul_cal_overlap", nover, 0);
    check("busy_level", nbusy, 0);

    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
